// File: rtl/tarot_pkg.sv
// tarot_pkg: shared deck constants, Q1.31 helpers, sequencer state encoding and LFSR setup.
package tarot_pkg;
   localparam int          DECK_SIZE = 78;
   localparam int          IDX_W     = 7;
   localparam int          WARMUP    = 16;
   localparam int          MAX_RETRY = 255;
   localparam logic [31:0] Q31_ONE   = 32'h7FFF_FFFF;
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] LFSR_SEED = 32'hACE1_ACE1;
   typedef enum logic [2:0] {
      S_IDLE,
      S_KICK,
      S_WAIT,
      S_CHECK,
      S_PRESENT,
      S_FINISH
   } state_t;
endpackage

// File: rtl/tarot_idx_map.sv
// tarot_idx_map: maps a Henon state pair to a card index (scaled top half of x) and orientation.
module tarot_idx_map
   import tarot_pkg::*;
#(
   parameter int DECK_SIZE = tarot_pkg::DECK_SIZE,
   parameter int IDX_W     = tarot_pkg::IDX_W
) (
   input  logic [15:0]      x_hi,
   input  logic             x_lsb,
   input  logic             y_msb,
   output logic [IDX_W-1:0] idx,
   output logic             rev
);
   assign idx = IDX_W'((32'(x_hi) * 32'(DECK_SIZE)) >> 16);
   assign rev = y_msb ^ x_lsb;
endmodule

// File: rtl/tarot_draw_sequencer.sv
// tarot_draw_sequencer: drives a henon_map_q31 core to deal distinct cards; TAROT_LFSR_PERTURB_EN adds LFSR perturbation.
module tarot_draw_sequencer
   import tarot_pkg::*;
#(
   parameter int DECK_SIZE = tarot_pkg::DECK_SIZE,
   parameter int WARMUP    = tarot_pkg::WARMUP,
   parameter int MAX_RETRY = tarot_pkg::MAX_RETRY,
   parameter int IDX_W     = tarot_pkg::IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic [31:0]      seed_x,
   input  logic [31:0]      seed_y,
   input  logic [31:0]      coef_a,
   input  logic [31:0]      coef_b,
   input  logic [IDX_W-1:0] num_cards,
   output logic             busy,
   output logic             card_valid,
   input  logic             card_ready,
   output logic [IDX_W-1:0] card_idx,
   output logic             card_reversed,
   output logic             draw_done,
   output logic             draw_err,
   output logic             core_start,
   output logic [31:0]      core_x,
   output logic [31:0]      core_y,
   output logic [31:0]      core_a,
   output logic [31:0]      core_b,
   output logic [31:0]      core_perturb,
   input  logic [31:0]      core_x_out,
   input  logic [31:0]      core_y_out,
   input  logic             core_done
);
   state_t                 state_q, state_d;
   logic [31:0]            x_q, x_d, y_q, y_d, a_q, a_d, b_q, b_d;
   logic [DECK_SIZE-1:0]   used_q, used_d;
   logic [15:0]            warm_q, warm_d, retry_q, retry_d;
   logic [IDX_W-1:0]       target_q, target_d, count_q, count_d, card_idx_q, card_idx_d;
   logic                   card_rev_q, card_rev_d, err_q, err_d;
   logic [IDX_W-1:0]       map_idx;
   logic                   map_rev;

   tarot_idx_map #(.DECK_SIZE(DECK_SIZE), .IDX_W(IDX_W)) u_map (
      .x_hi  (x_q[31:16]),
      .x_lsb (x_q[0]),
      .y_msb (y_q[31]),
      .idx   (map_idx),
      .rev   (map_rev)
   );

   // Next-state and datapath updates for the draw sequence.
   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      a_d        = a_q;
      b_d        = b_q;
      used_d     = used_q;
      warm_d     = warm_q;
      retry_d    = retry_q;
      target_d   = target_q;
      count_d    = count_q;
      card_idx_d = card_idx_q;
      card_rev_d = card_rev_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE: if (cfg_start) begin
            x_d      = seed_x;
            y_d      = seed_y;
            a_d      = coef_a;
            b_d      = coef_b;
            target_d = (num_cards > IDX_W'(DECK_SIZE)) ? IDX_W'(DECK_SIZE) : num_cards;
            used_d   = '0;
            warm_d   = '0;
            retry_d  = '0;
            count_d  = '0;
            err_d    = 1'b0;
            state_d  = (target_d == '0) ? S_FINISH : S_KICK;
         end
         S_KICK: state_d = S_WAIT;
         S_WAIT: if (core_done) begin
            x_d = core_x_out;
            y_d = core_y_out;
            if (warm_q < 16'(WARMUP)) begin
               warm_d  = warm_q + 16'd1;
               state_d = S_KICK;
            end else begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: if (used_q[map_idx]) begin
            retry_d = retry_q + 16'd1;
            err_d   = retry_d > 16'(MAX_RETRY);
            state_d = err_d ? S_FINISH : S_KICK;
         end else begin
            used_d[map_idx] = 1'b1;
            retry_d         = '0;
            card_idx_d      = map_idx;
            card_rev_d      = map_rev;
            state_d         = S_PRESENT;
         end
         S_PRESENT: if (card_ready) begin
            count_d = count_q + 1'b1;
            state_d = (count_d == target_q) ? S_FINISH : S_KICK;
         end
         S_FINISH: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         x_q        <= '0;
         y_q        <= '0;
         a_q        <= '0;
         b_q        <= '0;
         used_q     <= '0;
         warm_q     <= '0;
         retry_q    <= '0;
         target_q   <= '0;
         count_q    <= '0;
         card_idx_q <= '0;
         card_rev_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         a_q        <= a_d;
         b_q        <= b_d;
         used_q     <= used_d;
         warm_q     <= warm_d;
         retry_q    <= retry_d;
         target_q   <= target_d;
         count_q    <= count_d;
         card_idx_q <= card_idx_d;
         card_rev_q <= card_rev_d;
         err_q      <= err_d;
      end
   end

   assign busy          = state_q != S_IDLE;
   assign core_start    = state_q == S_KICK;
   assign card_valid    = state_q == S_PRESENT;
   assign draw_done     = state_q == S_FINISH;
   assign draw_err      = draw_done & err_q;
   assign card_idx      = card_idx_q;
   assign card_reversed = card_rev_q;
   assign core_x        = x_q;
   assign core_y        = y_q;
   assign core_a        = a_q;
   assign core_b        = b_q;

`ifdef TAROT_LFSR_PERTURB_EN
   logic [31:0] lfsr_q, lfsr_d;

   // Galois LFSR step on every core completion.
   always_comb begin
      lfsr_d = core_done ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 32'h0)) : lfsr_q;
   end

   // LFSR register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= LFSR_SEED;
      else     lfsr_q <= lfsr_d;
   end

   assign core_perturb = 32'($signed(lfsr_q) >>> 12);
`else
   assign core_perturb = '0;
`endif
endmodule

// File: tb/tb_tarot_draw_sequencer.sv
// tb_tarot_draw_sequencer: directed bench with a stub Henon core for tarot_draw_sequencer.
module tb_tarot_draw_sequencer;
   localparam int WARM  = 2;
   localparam int RETRY = 3;

   logic        clk = 1'b0, rst = 1'b1;
   logic        cfg_start = 1'b0, card_ready = 1'b1;
   logic [31:0] seed_x = '0, seed_y = '0, coef_a = '0, coef_b = '0;
   logic [6:0]  num_cards = '0;
   logic        busy, card_valid, card_reversed, draw_done, draw_err, core_start;
   logic [6:0]  card_idx;
   logic [31:0] core_x, core_y, core_a, core_b, core_perturb;
   logic [31:0] core_x_out = '0, core_y_out = '0;
   logic        core_done = 1'b0;

   int passed = 0, failed = 0, total = 0;

   always #5 clk = ~clk;

   tarot_draw_sequencer #(.DECK_SIZE(78), .WARMUP(WARM), .MAX_RETRY(RETRY), .IDX_W(7)) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start),
      .seed_x(seed_x), .seed_y(seed_y), .coef_a(coef_a), .coef_b(coef_b), .num_cards(num_cards),
      .busy(busy), .card_valid(card_valid), .card_ready(card_ready), .card_idx(card_idx),
      .card_reversed(card_reversed), .draw_done(draw_done), .draw_err(draw_err),
      .core_start(core_start), .core_x(core_x), .core_y(core_y), .core_a(core_a), .core_b(core_b),
      .core_perturb(core_perturb), .core_x_out(core_x_out), .core_y_out(core_y_out),
      .core_done(core_done)
   );

   // Stub core: answers each core_start two cycles later with the next queued x (0 when empty).
   logic [31:0] stub_q[$];
   logic [31:0] stub_y = '0;
   logic        spur = 1'b0;
   int          cnt = 0;
   always @(posedge clk) begin
      core_done <= 1'b0;
      if (rst) cnt <= 0;
      else if (core_start) cnt <= 2;
      else if (cnt == 2) cnt <= 1;
      else if (cnt == 1) begin
         cnt        <= 0;
         core_done  <= 1'b1;
         core_y_out <= stub_y;
         core_x_out <= (stub_q.size() > 0) ? stub_q.pop_front() : 32'h0;
      end else if (spur) begin
         core_done  <= 1'b1;
         core_x_out <= 32'hFFFF_FFFF;
      end
   end

   // Monitor: counts core starts, card transfers and completions.
   int         n_start = 0, n_xfer = 0, n_done = 0;
   logic [6:0] got_idx [0:255];
   logic       got_rev [0:255];
   always @(posedge clk) begin
      if (core_start) n_start <= n_start + 1;
      if (card_valid && card_ready) begin
         got_idx[n_xfer] <= card_idx;
         got_rev[n_xfer] <= card_reversed;
         n_xfer          <= n_xfer + 1;
      end
      if (draw_done) n_done <= n_done + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start(input logic [6:0] n);
      @(negedge clk);
      num_cards = n;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int c;
      c = 0;
      while (!card_valid && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk(tag, card_valid, 1);
   endtask

   task automatic wait_done(input string tag, input int budget, output logic err);
      int c;
      c = 0;
      while (!draw_done && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk(tag, draw_done, 1);
      err = draw_err;
      @(negedge clk);
   endtask

   initial begin
      int         bs, bx, bd;
      logic       err, ok;
      logic [77:0] mask;
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {busy, card_valid, draw_done, draw_err, core_start, card_reversed, card_idx}, 0);
      chk("rst_core", core_x | core_y | core_a | core_b | core_perturb, 0);
      rst = 1'b0;

      // Two cards, idx 39 then 77, both reversed via y msb.
      stub_y = 32'h8000_0000;
      stub_q = '{32'h1111_1111, 32'h2222_2223, 32'h8000_0000, 32'hFFFF_0000};
      seed_x = 32'h1234_5678; seed_y = 32'h0BAD_F00D; coef_a = 32'hA000_0001; coef_b = 32'h3000_0002;
      bs = n_start; bx = n_xfer;
      start(2);
      chk("t1_kick", {busy, core_start}, 2'b11);
      chk("t1_core_x", core_x, 32'h1234_5678);
      chk("t1_core_y", core_y, 32'h0BAD_F00D);
      chk("t1_core_ab", core_a ^ core_b, 32'hA000_0001 ^ 32'h3000_0002);
      chk("t1_perturb", core_perturb, 0);
      wait_valid("t1_valid", 100);
      chk("t1_warm_iters", n_start - bs, WARM + 1);
      wait_done("t1_done", 200, err);
      chk("t1_err", err, 0);
      chk("t1_xfers", n_xfer - bx, 2);
      chk("t1_idx0", got_idx[bx], 39);
      chk("t1_idx1", got_idx[bx+1], 77);
      chk("t1_rev", {got_rev[bx], got_rev[bx+1]}, 2'b11);
      chk("t1_starts", n_start - bs, 4);
      chk("t1_idle", busy, 0);

      // Duplicate idx 0 is retried silently before idx 39 is accepted.
      stub_y = 32'h0;
      stub_q = '{32'h0000_0001, 32'h0000_0003, 32'h0, 32'h0, 32'h8000_0000};
      bs = n_start; bx = n_xfer;
      start(2);
      wait_done("t2_done", 300, err);
      chk("t2_err", err, 0);
      chk("t2_xfers", n_xfer - bx, 2);
      chk("t2_idx0", got_idx[bx], 0);
      chk("t2_idx1", got_idx[bx+1], 39);
      chk("t2_rev", {got_rev[bx], got_rev[bx+1]}, 2'b00);
      chk("t2_starts", n_start - bs, 5);

      // Consumer stalls 10 cycles with spurious core_done pulses.
      stub_y = 32'h8000_0000;
      stub_q = '{32'h5, 32'h7, 32'h4000_0001};
      card_ready = 1'b0;
      bx = n_xfer;
      start(1);
      wait_valid("t3_valid", 100);
      bs = n_start;
      ok = 1'b1;
      spur = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (!card_valid || card_idx != 7'd19 || core_start) ok = 1'b0;
      end
      spur = 1'b0;
      chk("t3_hold", ok, 1);
      chk("t3_idx", card_idx, 19);
      chk("t3_rev", card_reversed, 0);
      chk("t3_no_iter", n_start - bs, 0);
      card_ready = 1'b1;
      wait_done("t3_done", 50, err);
      chk("t3_xfers", n_xfer - bx, 1);

      // Zero cards: immediate completion, no card, no core activity.
      bs = n_start; bx = n_xfer; bd = n_done;
      start(0);
      chk("t4_zero_done", {draw_done, draw_err, card_valid}, 3'b100);
      ok = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (draw_done || card_valid || busy) ok = 1'b0;
      end
      chk("t4_zero_quiet", ok, 1);
      chk("t4_zero_cnt", {n_start - bs, n_xfer - bx, n_done - bd}, {32'd0, 32'd0, 32'd1});

      // 100 requested clamps to a full deck, fed in descending order.
      stub_y = 32'h0;
      stub_q = '{32'h9, 32'hB};
      for (int k = 77; k >= 0; k--) stub_q.push_back(((k * 65536 + 77) / 78) << 16);
      bs = n_start; bx = n_xfer;
      start(100);
      wait_done("t4_full_done", 3000, err);
      chk("t4_full_err", err, 0);
      chk("t4_full_xfers", n_xfer - bx, 78);
      mask = '0;
      for (int i = 0; i < 78; i++) mask[got_idx[bx+i]] = 1'b1;
      chk("t4_full_deck", &mask, 1);
      chk("t4_full_first", got_idx[bx], 77);
      chk("t4_full_last", got_idx[bx+77], 0);

      // Constant x=0: one card then abort after RETRY+1 duplicates.
      stub_q.delete();
      bs = n_start; bx = n_xfer;
      start(5);
      wait_done("t5_done", 300, err);
      chk("t5_err", err, 1);
      chk("t5_xfers", n_xfer - bx, 1);
      chk("t5_idx", got_idx[bx], 0);
      chk("t5_starts", n_start - bs, WARM + 1 + RETRY + 1);

      // Asynchronous reset while the core is busy.
      stub_q = '{32'h1, 32'h3, 32'h5};
      start(3);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (core_start) ok = 1'b1;
         else @(negedge clk);
      end
      chk("t6_kick_seen", ok, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6_rst_ctrl", {busy, card_valid, draw_done, draw_err, core_start, card_reversed, card_idx}, 0);
      chk("t6_rst_core", core_x | core_y | core_a | core_b, 0);
      @(negedge clk);
      rst = 1'b0;
      stub_q.delete();

      // cfg_start while busy is ignored.
      stub_q = '{32'h1, 32'h3, 32'h8000_0000};
      bx = n_xfer; bd = n_done;
      start(1);
      num_cards = 7'd5;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      wait_done("t6_done", 200, err);
      repeat (5) @(negedge clk);
      chk("t6_xfers", n_xfer - bx, 1);
      chk("t6_idx", got_idx[bx], 39);
      chk("t6_one_done", n_done - bd, 1);
      chk("t6_idle", busy, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
